// File: rtl/button_scan_ctrl.sv
// button_scan_ctrl: time-shared round-robin debounce for NUM_BTN buttons with a valid/ready event port
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   btn        raw button levels (async), 1 = pressed
//   stable     debounced level per button
//   evt_valid  event pending
//   evt_ready  consumer accepts event when evt_valid && evt_ready
//   evt_idx    index of button that changed
//   evt_level  new level, 1 = press, 0 = release
//   scan_idx   button currently being scanned
module button_scan_ctrl #(
   parameter int NUM_BTN       = 4,
   parameter int IDX_W         = 2,
   parameter int GAP_CYCLES    = 10,
   parameter int SETTLE_CYCLES = 1000000,
   parameter int CNT_W         = 20
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_BTN-1:0] btn,
   output logic [NUM_BTN-1:0] stable,
   output logic               evt_valid,
   input  logic               evt_ready,
   output logic [IDX_W-1:0]   evt_idx,
   output logic               evt_level,
   output logic [IDX_W-1:0]   scan_idx
);
   typedef enum logic [1:0] {GAP, SETTLE, CMP, EMIT} state_t;
   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [NUM_BTN-1:0] sync1, btn_sync;
   logic               s1, s2;
   logic [IDX_W-1:0]   next_idx;
   always_comb next_idx = (scan_idx == IDX_W'(NUM_BTN-1)) ? '0 : scan_idx + 1'b1;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1    <= '0;
         btn_sync <= '0;
      end else begin
         sync1    <= btn;
         btn_sync <= sync1;
      end
   end
   // cnt is only nonzero inside GAP/SETTLE; it is cleared on every exit so both start at 0
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= GAP;
         cnt       <= '0;
         s1        <= 1'b0;
         s2        <= 1'b0;
         stable    <= '0;
         evt_valid <= 1'b0;
         evt_idx   <= '0;
         evt_level <= 1'b0;
         scan_idx  <= '0;
      end else begin
         case (state)
            GAP:
               if (cnt == CNT_W'(GAP_CYCLES-1)) begin
                  s1    <= btn_sync[scan_idx];
                  cnt   <= '0;
                  state <= SETTLE;
               end else cnt <= cnt + 1'b1;
            SETTLE:
               if (cnt == CNT_W'(SETTLE_CYCLES-1)) begin
                  s2    <= btn_sync[scan_idx];
                  cnt   <= '0;
                  state <= CMP;
               end else cnt <= cnt + 1'b1;
            CMP:
               // both samples must agree and differ from the debounced level to count as a change
               if (s1 == s2 && s1 != stable[scan_idx]) begin
                  stable[scan_idx] <= s1;
                  evt_idx          <= scan_idx;
                  evt_level        <= s1;
                  evt_valid        <= 1'b1;
                  state            <= EMIT;
               end else begin
                  scan_idx <= next_idx;
                  state    <= GAP;
               end
            EMIT:
               if (evt_ready) begin
                  evt_valid <= 1'b0;
                  scan_idx  <= next_idx;
                  state     <= GAP;
               end
            default: state <= GAP;
         endcase
      end
   end
endmodule

// File: tb/tb_button_scan_ctrl.sv
// tb_button_scan_ctrl: scoreboard bench for button_scan_ctrl with a 7-cycle slot
module tb_button_scan_ctrl;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] btn = '0;
   logic [3:0] stable;
   logic       evt_valid;
   logic       evt_ready = 1'b0;
   logic [1:0] evt_idx;
   logic       evt_level;
   logic [1:0] scan_idx;
   int         n_cmp = 0;
   int         n_err = 0;
   logic [2:0] q[$];
   button_scan_ctrl #(.NUM_BTN(4), .IDX_W(2), .GAP_CYCLES(2), .SETTLE_CYCLES(4), .CNT_W(20)) dut (
      .clk(clk), .rst_n(rst_n), .btn(btn), .stable(stable), .evt_valid(evt_valid),
      .evt_ready(evt_ready), .evt_idx(evt_idx), .evt_level(evt_level), .scan_idx(scan_idx)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   always @(negedge clk) begin : mon
      logic [2:0] e;
      if (rst_n && evt_valid && evt_ready) begin
         if (q.size() == 0) chk("evt_unexpected", {evt_idx, evt_level}, 3'h7);
         else begin
            e = q.pop_front();
            chk("evt", {evt_idx, evt_level}, e);
         end
      end
   end
   task automatic drain();
      int k = 0;
      while (q.size() != 0 && k < 100) begin
         @(negedge clk);
         k++;
      end
      chk("drain", q.size(), 0);
      repeat (2) @(negedge clk);
   endtask
   task automatic wait_valid();
      int k = 0;
      while (!evt_valid && k < 100) begin
         @(negedge clk);
         k++;
      end
      chk("wait_valid", evt_valid, 1);
   endtask
   task automatic wait_scan(input logic [1:0] v);
      int k = 0;
      while (scan_idx !== v && k < 100) begin
         @(negedge clk);
         k++;
      end
      chk("wait_scan", scan_idx, v);
   endtask
   initial begin
      #1;
      chk("rst_stable", stable, 0);
      chk("rst_valid", evt_valid, 0);
      chk("rst_idx", evt_idx, 0);
      chk("rst_level", evt_level, 0);
      chk("rst_scan", scan_idx, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      for (int c = 1; c <= 35; c++) begin
         @(negedge clk);
         if (c % 7 == 3) begin
            chk("scan_step", scan_idx, (c / 7) % 4);
            chk("idle_valid", evt_valid, 0);
         end
      end
      evt_ready = 1'b1;
      btn = 4'b0100;
      q.push_back({2'd2, 1'b1});
      drain();
      chk("press_stable", stable, 4'b0100);
      repeat (40) @(negedge clk);
      chk("no_more_evt", q.size(), 0);
      btn = 4'b0000;
      q.push_back({2'd2, 1'b0});
      drain();
      evt_ready = 1'b0;
      btn = 4'b0100;
      q.push_back({2'd2, 1'b1});
      wait_valid();
      repeat (20) @(negedge clk);
      chk("stall_valid", evt_valid, 1);
      chk("stall_idx", evt_idx, 2);
      chk("stall_level", evt_level, 1);
      chk("stall_scan", scan_idx, 2);
      chk("stall_stable", stable, 4'b0100);
      @(posedge clk);
      #1 evt_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("release_valid", evt_valid, 0);
      chk("release_scan", scan_idx, 3);
      chk("stall_drained", q.size(), 0);
      wait_scan(2'd0);
      btn = 4'b0110;
      repeat (7) @(negedge clk);
      chk("bounce_scan1", scan_idx, 1);
      @(negedge clk);
      btn = 4'b0100;
      repeat (6) @(negedge clk);
      chk("bounce_scan2", scan_idx, 2);
      chk("bounce_stable", stable, 4'b0100);
      chk("bounce_valid", evt_valid, 0);
      btn = 4'b0000;
      q.push_back({2'd2, 1'b0});
      drain();
      chk("release_stable", stable, 4'b0000);
      evt_ready = 1'b0;
      btn = 4'b0001;
      q.push_back({2'd0, 1'b1});
      wait_valid();
      chk("pre_rst_idx", evt_idx, 0);
      chk("pre_rst_stable", stable, 4'b0001);
      #2 rst_n = 1'b0;
      #1;
      chk("async_valid", evt_valid, 0);
      chk("async_stable", stable, 0);
      chk("async_scan", scan_idx, 0);
      q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      evt_ready = 1'b1;
      q.push_back({2'd0, 1'b1});
      @(negedge clk);
      chk("restart_scan", scan_idx, 0);
      drain();
      chk("reissue_stable", stable, 4'b0001);
      repeat (30) @(negedge clk);
      chk("final_queue", q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
